rv32i_decode_stage: RTL

Pipelined RV32I decode stage that produces the packed `{funct7, funct3, opcode}` operation word and both ALU operands, the producer end of the execute-stage ALU interface. Sits between fetch and execute: accepts instruction+PC through a valid/ready handshake, reads the register file, and forms immediates. Results are registered with a 2-entry skid buffer so `if_ready` is a registered signal and full throughput is held under backpressure.

---
 rtl/rv32i_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: decodes the instruction, reads operands, forms immediates and produces {funct7,funct3,opcode} plus both ALU operands.
// Latency: 1 cycle from the accepting edge to ex_valid; results sit in a main register backed by a one-entry skid register.
// Backpressure: if_ready is registered (= skid empty), so full throughput holds under ex_ready stalls. Define DECODE_WB_BYPASS_EN to forward wb_data into the operands.
module rv32i_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [16:0]     ex_full_op,
    output logic [XLEN-1:0] ex_value1,
    output logic [XLEN-1:0] ex_value2,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [16:0]     full_op;
        logic [XLEN-1:0] value1;
        logic [XLEN-1:0] value2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } dec_t;

    // instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rd       = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // immediates (XLEN is fixed at 32)
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign shamt = {{(XLEN-5){1'b0}}, if_instr[24:20]};

    // register operands: x0 always reads zero
    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;

`ifdef DECODE_WB_BYPASS_EN
    // forward the write-back value when it targets a source register this cycle
    always_comb begin
        rs1_v = rs1_data;
        rs2_v = rs2_data;
        if (wb_en && (wb_rd == rs1_addr)) rs1_v = wb_data;
        if (wb_en && (wb_rd == rs2_addr)) rs2_v = wb_data;
        if (rs1_addr == 5'd0) rs1_v = '0;
        if (rs2_addr == 5'd0) rs2_v = '0;
    end
`else
    // register file is write-first, so the write-back snoop is not needed
    logic wb_unused;
    assign wb_unused = ^{wb_en, wb_rd, wb_data};
    assign rs1_v = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_v = (rs2_addr == 5'd0) ? '0 : rs2_data;
`endif

    dec_t dec;

    // decode the offered instruction into an execute-stage payload
    always_comb begin
        logic       legal;
        logic       we;
        logic [6:0] f7_out;
        logic [2:0] f3_out;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;

        legal  = 1'b1;
        we     = 1'b0;
        f7_out = 7'b0;
        f3_out = funct3;
        v1     = '0;
        v2     = '0;

        case (opcode)
            OPC_OP: begin
                legal  = (funct7 == F7_ZERO) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                f7_out = funct7;
                v1     = rs1_v;
                v2     = rs2_v;
                we     = 1'b1;
            end
            OPC_OP_IMM: begin
                v1 = rs1_v;
                v2 = imm_i;
                we = 1'b1;
                // shifts carry funct7 in the op word, so the operand is just the shift amount
                if (funct3 == 3'b001) begin
                    legal  = (funct7 == F7_ZERO);
                    f7_out = funct7;
                    v2     = shamt;
                end else if (funct3 == 3'b101) begin
                    legal  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    f7_out = funct7;
                    v2     = shamt;
                end
            end
            OPC_JAL: begin
                f3_out = 3'b000;
                v1     = if_pc;
                v2     = XLEN'(4);
                we     = 1'b1;
            end
            OPC_JALR: begin
                v1 = if_pc;
                v2 = XLEN'(4);
                we = 1'b1;
            end
            OPC_LUI: begin
                f3_out = 3'b000;
                v2     = imm_u;
                we     = 1'b1;
            end
            OPC_AUIPC: begin
                f3_out = 3'b000;
                v1     = if_pc;
                v2     = imm_u;
                we     = 1'b1;
            end
            OPC_BRANCH: begin
                v1 = if_pc;
                v2 = imm_b;
            end
            OPC_LOAD: begin
                v1 = rs1_v;
                v2 = imm_i;
                we = 1'b1;
            end
            OPC_STORE: begin
                v1 = rs1_v;
                v2 = imm_s;
            end
            default: legal = 1'b0;
        endcase

        if (if_instr[1:0] != 2'b11) legal = 1'b0;

        dec.pc = if_pc;
        dec.rd = rd;
        if (legal) begin
            dec.full_op = {f7_out, f3_out, opcode};
            dec.value1  = v1;
            dec.value2  = v2;
            dec.rs1_val = rs1_v;
            dec.rs2_val = rs2_v;
            dec.rd_we   = we && (rd != 5'd0);
            dec.illegal = 1'b0;
        end else begin
            dec.full_op = {funct7, funct3, opcode};
            dec.value1  = '0;
            dec.value2  = '0;
            dec.rs1_val = '0;
            dec.rs2_val = '0;
            dec.rd_we   = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    // pipeline state
    dec_t main_q, main_d;
    dec_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic if_ready_q, if_ready_d;
    logic accept;
    logic drain;

    assign accept = if_valid && if_ready_q;
    assign drain  = main_vld_q && ex_ready;

    // main/skid next state: flush wins, skid refills main, stalled main diverts input to skid
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // if_ready is low while skid is occupied, so nothing is accepted here
            if (drain) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (main_vld_q && !ex_ready) begin
            if (accept) begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end else begin
            // main empty or draining this edge: new op goes straight in, no bubble
            main_vld_d = accept;
            if (accept) main_d = dec;
        end

        if_ready_d = !skid_vld_d;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            if_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            if_ready_q <= if_ready_d;
        end
    end

    assign if_ready   = if_ready_q;
    assign ex_valid   = main_vld_q;
    assign ex_full_op = main_q.full_op;
    assign ex_value1  = main_q.value1;
    assign ex_value2  = main_q.value2;
    assign ex_rs1_val = main_q.rs1_val;
    assign ex_rs2_val = main_q.rs2_val;
    assign ex_rd      = main_q.rd;
    assign ex_rd_we   = main_q.rd_we;
    assign ex_pc      = main_q.pc;
    assign ex_illegal = main_q.illegal;

endmodule
